// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, line timing
// constants and default timeouts.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACC  = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_t;

  localparam int CLK_HZ           = 100_000_000;
  localparam int BAUD             = 9600;
  localparam int CYCLES_PER_BIT   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DEF_HOLD_TIMEOUT = 1_000_000;
  localparam int DEF_ACC_TIMEOUT  = 16;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serialiser handshake bundle of the UART transmit arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
  parameter int N_REQ = 4
);
  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_last;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   ack;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic [IW-1:0]      owner;
  logic               locked;
  logic               acc_err;

  modport slave (
    input  req, req_last, req_data, tx_busy,
    output ack, tx_start, tx_data, owner, locked, acc_err
  );

  modport master (
    output req, req_last, req_data, tx_busy,
    input  ack, tx_start, tx_data, owner, locked, acc_err
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'((int'(ptr) + k) % N);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-wide UART serialiser between N_REQ
// requesters, with per-message locking and serialiser-acceptance timeout.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = DEF_HOLD_TIMEOUT,
  parameter int ACC_TIMEOUT  = DEF_ACC_TIMEOUT
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  localparam int AW = $clog2(ACC_TIMEOUT + 1);

  arb_state_t       state, state_nxt;
  logic [IW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]    owner_r, owner_nxt;
  logic             locked_r, locked_nxt;
  logic [N_REQ-1:0] ack_r, ack_nxt;
  logic             tx_start_r, tx_start_nxt;
  logic [7:0]       tx_data_r, tx_data_nxt;
  logic             acc_err_r, acc_err_nxt;
  logic [AW-1:0]    acc_cnt, acc_cnt_nxt;
  logic [HW-1:0]    hold_cnt, hold_cnt_nxt;

  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             issue_idle, issue_hold, acc_to, byte_done, hold_to;
  logic [IW-1:0]    win_idx, ptr_after;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // A new byte is never launched while the serialiser still reports busy,
  // which also covers a byte left in flight across a reset.
  assign issue_idle = (state == IDLE) && pick_any && !bus.tx_busy;
  assign issue_hold = (state == HOLD) && bus.req[owner_r] && !bus.tx_busy;
  assign acc_to     = (state == WAIT_ACC) && !bus.tx_busy &&
                      (acc_cnt == AW'(ACC_TIMEOUT - 1));
  assign byte_done  = acc_to || ((state == WAIT_DONE) && !bus.tx_busy);
  assign hold_to    = (state == HOLD) && !issue_hold &&
                      (hold_cnt == HW'(HOLD_TIMEOUT - 1));
  assign win_idx    = (state == HOLD) ? owner_r : pick_idx;
  assign ptr_after  = (owner_r == IW'(N_REQ - 1)) ? '0 : owner_r + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner_r    <= '0;
      locked_r   <= 1'b0;
      ack_r      <= '0;
      tx_start_r <= 1'b0;
      tx_data_r  <= '0;
      acc_err_r  <= 1'b0;
      acc_cnt    <= '0;
      hold_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      owner_r    <= owner_nxt;
      locked_r   <= locked_nxt;
      ack_r      <= ack_nxt;
      tx_start_r <= tx_start_nxt;
      tx_data_r  <= tx_data_nxt;
      acc_err_r  <= acc_err_nxt;
      acc_cnt    <= acc_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (issue_idle) state_nxt = WAIT_ACC;
      WAIT_ACC: begin
        if (bus.tx_busy)  state_nxt = WAIT_DONE;
        else if (acc_to)  state_nxt = locked_r ? HOLD : IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_nxt = locked_r ? HOLD : IDLE;
      HOLD: begin
        if (issue_hold)   state_nxt = WAIT_ACC;
        else if (hold_to) state_nxt = IDLE;
      end
      default:           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack_nxt      = '0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data_r;
    owner_nxt    = owner_r;
    locked_nxt   = locked_r;
    rr_ptr_nxt   = rr_ptr;
    acc_err_nxt  = acc_err_r;
    acc_cnt_nxt  = acc_cnt;
    hold_cnt_nxt = hold_cnt;

    if (issue_idle || issue_hold) begin
      if (issue_idle) ack_nxt = pick_grant;
      else            ack_nxt[owner_r] = 1'b1;
      tx_start_nxt = 1'b1;
      tx_data_nxt  = bus.req_data[{win_idx, 3'b000} +: 8];
      owner_nxt    = win_idx;
      locked_nxt   = ~bus.req_last[win_idx];
      acc_cnt_nxt  = '0;
    end

    if ((state == WAIT_ACC) && !bus.tx_busy && !acc_to)
      acc_cnt_nxt = acc_cnt + 1'b1;
    if (acc_to)
      acc_err_nxt = 1'b1;

    if (byte_done) begin
      hold_cnt_nxt = '0;
      if (!locked_r) rr_ptr_nxt = ptr_after;
    end

    // An idle owner loses its lock and the pointer moves past it.
    if ((state == HOLD) && !issue_hold) begin
      if (hold_to) begin
        locked_nxt = 1'b0;
        rr_ptr_nxt = ptr_after;
      end else begin
        hold_cnt_nxt = hold_cnt + 1'b1;
      end
    end
  end

  assign bus.ack      = ack_r;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.owner    = owner_r;
  assign bus.locked   = locked_r;
  assign bus.acc_err  = acc_err_r;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one byte-wide UART transmitter (start/busy interface, 8N1, 9600 baud at 100 MHz clk) between N_REQ on-chip requesters.
- Round-robin arbitration, byte handshake per requester, message locking so multi-byte messages are not interleaved.
- Sits between the echo and status logic and the UART TX serialiser; the serialiser drives TXD.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_TIMEOUT, 1000000, clk cycles an owner may idle mid-message before its lock is revoked (10 ms).
- ACC_TIMEOUT, 16, clk cycles to wait for tx_busy to rise after tx_start.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester byte valid; held until ack.
- req_last  in  N_REQ  qualifies req: byte is last of message.
- req_data  in  8*N_REQ  byte i at bits [8i+7:8i].
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- tx_start  out  1  one-cycle start pulse to the serialiser.
- tx_data  out  8  byte to the serialiser; stable from tx_start until tx_busy falls.
- tx_busy  in  1  serialiser busy, start bit through stop bit.
- owner  out  clog2(N_REQ)  current or last grant index.
- locked  out  1  a message is in progress (owner holds the lock).
- acc_err  out  1  sticky: serialiser failed to go busy within ACC_TIMEOUT; cleared only by reset.

Behaviour:
- Reset values: ack=0, tx_start=0, tx_data=0, owner=0, locked=0, acc_err=0, rr pointer=0 (requester 0 highest priority), state IDLE, timers 0.
- Reset asserted mid-operation: all of the above take effect on the next edge. An in-flight serial byte is not aborted (serialiser's concern). Arbiter waits in IDLE for tx_busy=0 before issuing.
- All outputs are registered.
- IDLE:
  - Requires any req and tx_busy=0.
  - Pick the first set req scanning from rr pointer upward, with wrap-around.
  - Next edge: tx_start=1, tx_data=req_data[winner], ack[winner]=1, owner=winner, locked=~req_last[winner].
  - Go to WAIT_ACC.
  - Latency from req sampled to tx_start high: 1 cycle.
- WAIT_ACC:
  - tx_start and ack return to 0.
  - tx_busy=1 → WAIT_DONE.
  - Counter reaches ACC_TIMEOUT → set acc_err, treat the byte as sent, go to DONE handling.
- WAIT_DONE: tx_busy=0 → DONE handling.
- DONE handling:
  - If locked=1 → HOLD.
  - Otherwise rr pointer=owner+1 (mod N_REQ) → IDLE.
- HOLD:
  - Only req[owner] is considered. Other requesters are starved by design.
  - req[owner]=1 → issue exactly as in IDLE, but without arbitration. locked=~req_last[owner].
  - Hold counter resets on every issue.
  - Counter reaches HOLD_TIMEOUT → locked=0, rr pointer=owner+1, → IDLE.
- ack is never asserted to a requester whose req is low in the sampling cycle.
- At most one ack bit is set per cycle.
- Simultaneous requests: the lowest index at or after the rr pointer wins.
- A req dropped before ack is a protocol violation; the byte is simply not sent.
- N_REQ=1 degenerates to a pass-through with locking.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, WAIT_ACC, WAIT_DONE, HOLD)
  - CLK_HZ=100000000, BAUD=9600, CYCLES_PER_BIT=10417
  - default timeouts
- One sub-module: rr_pick. Combinational round-robin priority picker; inputs request vector and pointer, outputs a one-hot winner and index.

Test Plan:
1. Single requester 2 sends 0x55 with req_last=1 → tx_start 1 cycle after req, tx_data=0x55, ack[2] single pulse, locked=0. TXD of the attached serialiser shows 0x55 LSB-first, 104 µs per bit. Next idle pointer=3.
2. req[0] and req[1] (req_last=1) both held continuously after reset → bytes served in order 0,1,0,1. No tx_start while tx_busy=1.
3. Requester 1 sends a 3-byte message 0x7D,0x55,0xAA (last on third) while req[3] is held → the three bytes go out back-to-back before any ack[3]. locked=1 after the first and second bytes, 0 after the third.
4. Requester 0 sends one byte with req_last=0, then goes silent; req[2] pending → after HOLD_TIMEOUT (set to 50 in the bench), locked drops and requester 2 is granted on the next cycle.
5. Serialiser stub never raises tx_busy → acc_err=1 after ACC_TIMEOUT cycles. The arbiter returns to IDLE and serves the next request. acc_err stays 1 until reset.
6. Reset pulsed during WAIT_DONE of a locked message → outputs at reset values next cycle, pointer=0. No tx_start until tx_busy=0 and req seen again.
